// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the binary-to-BCD converter and the downstream
// seven-segment decoders: FSM states, digit width and the blank segment pattern.
package bin2bcd_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FIN   = 2'd2
  } state_e;

  localparam int BCD_W = 4;

  // Segment pattern for an unlit digit (active-low segments, all off).
  localparam logic [6:0] SEG7_BLANK = 7'h7F;

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 before the
// shift so that the shifted value carries correctly into the next digit.
module bin2bcd_seq_add3
  import bin2bcd_seq_pkg::*;
(
  input  logic [BCD_W-1:0] din_i,
  output logic [BCD_W-1:0] dout_o
);

  assign dout_o = (din_i >= 4'd5) ? din_i + 4'd3 : din_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock, with
// saturation to all nines on overflow and a leading-zero blank mask.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      START,
  input  logic [BIN_W-1:0]          BIN,
  output logic                      BUSY,
  output logic                      DONE,
  output logic [BCD_W*DIGITS-1:0]   BCD,
  output logic [DIGITS-1:0]         LZB,
  output logic                      OVF
);

  localparam int SCR_W = BCD_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam logic [63:0]      LIMIT = 64'(pow10(DIGITS));
  localparam logic [SCR_W-1:0] SAT   = {DIGITS{4'h9}};
  localparam logic [DIGITS-1:0] LZB_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  state_e             state_q;
  logic [BIN_W-1:0]   shift_q;
  logic [SCR_W-1:0]   scratch_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q;
  logic               busy_q;
  logic               done_q;
  logic [SCR_W-1:0]   bcd_q;
  logic [DIGITS-1:0]  lzb_q;
  logic               ovf_o_q;

  logic [SCR_W-1:0]   adj;
  logic [SCR_W-1:0]   scratch_d;
  logic [BIN_W-1:0]   shift_d;
  logic               shift_out_unused;
  logic [DIGITS-1:0]  lzb_d;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_add3
      bin2bcd_seq_add3 u_add3 (
        .din_i  (scratch_q[gi*BCD_W +: BCD_W]),
        .dout_o (adj[gi*BCD_W +: BCD_W])
      );
    end
  endgenerate

  // The top scratch bit falls off the end; that only happens on overflow.
  assign {shift_out_unused, scratch_d, shift_d} = {adj, shift_q, 1'b0};

  always_comb begin
    logic all_zero;
    lzb_d    = '0;
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero & (scratch_q[i*BCD_W +: BCD_W] == 4'd0);
      lzb_d[i] = all_zero;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      lzb_q     <= LZB_RST;
      ovf_o_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            shift_q   <= BIN;
            scratch_q <= '0;
            cnt_q     <= CNT_W'(BIN_W);
            ovf_q     <= (64'(BIN) >= LIMIT);
            busy_q    <= 1'b1;
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          scratch_q <= scratch_d;
          shift_q   <= shift_d;
          cnt_q     <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= ST_FIN;
        end
        ST_FIN: begin
          bcd_q   <= ovf_q ? SAT : scratch_q;
          lzb_q   <= ovf_q ? '0 : lzb_d;
          ovf_o_q <= ovf_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign BCD  = bcd_q;
  assign LZB  = lzb_q;
  assign OVF  = ovf_o_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and random checks of bin2bcd_seq in the default (14-bit, 4-digit)
// and a reduced (10-bit, 3-digit) configuration running side by side.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        d_start = 1'b0;
  logic [13:0] d_bin = '0;
  logic        d_busy, d_done, d_ovf;
  logic [15:0] d_bcd;
  logic [3:0]  d_lzb;

  logic        s_start = 1'b0;
  logic [9:0]  s_bin = '0;
  logic        s_busy, s_done, s_ovf;
  logic [11:0] s_bcd;
  logic [2:0]  s_lzb;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bin2bcd_seq u_dflt (
    .CLK(clk), .RST(rst), .START(d_start), .BIN(d_bin),
    .BUSY(d_busy), .DONE(d_done), .BCD(d_bcd), .LZB(d_lzb), .OVF(d_ovf)
  );

  bin2bcd_seq #(.BIN_W(10), .DIGITS(3)) u_small (
    .CLK(clk), .RST(rst), .START(s_start), .BIN(s_bin),
    .BUSY(s_busy), .DONE(s_done), .BCD(s_bcd), .LZB(s_lzb), .OVF(s_ovf)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model by division/modulo.
  function automatic int lim_of(input int nd);
    int lim;
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    return lim;
  endfunction

  function automatic logic [31:0] ref_bcd(input int v, input int nd);
    logic [31:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = (v >= lim_of(nd)) ? 4'h9 : 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_lzb(input int v, input int nd);
    logic [31:0] r;
    logic        allz;
    int          p;
    r    = '0;
    allz = 1'b1;
    p    = lim_of(nd) / 10;
    if (v < lim_of(nd)) begin
      for (int i = nd - 1; i >= 1; i--) begin
        allz = allz & (((v / p) % 10) == 0);
        r[i] = allz;
        p    = p / 10;
      end
    end
    return r;
  endfunction

  task automatic wait_d(input int lat0, output int lat);
    lat = lat0;
    while (!d_done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_both(input int vd, input logic [15:0] ebd, input logic [3:0] eld, input logic eod,
                          input int vs, input logic [11:0] ebs, input logic [2:0] els, input logic eos);
    int   c;
    logic got_d, got_s;
    d_bin = 14'(vd); s_bin = 10'(vs);
    d_start = 1'b1; s_start = 1'b1;
    @(posedge clk); #1;
    d_start = 1'b0; s_start = 1'b0;
    c = 0; got_d = 1'b0; got_s = 1'b0;
    while (!(got_d && got_s) && c < 40) begin
      @(posedge clk); #1;
      c++;
      if (c == 14) check_eq("busy_mid", 32'(d_busy), 32'd1);
      if (d_done && !got_d) begin
        got_d = 1'b1;
        check_eq("lat_d", c, 15);
        check_eq("busy_done_d", 32'(d_busy), 32'd0);
        check_eq("bcd_d", 32'(d_bcd), 32'(ebd));
        check_eq("lzb_d", 32'(d_lzb), 32'(eld));
        check_eq("ovf_d", 32'(d_ovf), 32'(eod));
      end
      if (s_done && !got_s) begin
        got_s = 1'b1;
        check_eq("lat_s", c, 11);
        check_eq("bcd_s", 32'(s_bcd), 32'(ebs));
        check_eq("lzb_s", 32'(s_lzb), 32'(els));
        check_eq("ovf_s", 32'(s_ovf), 32'(eos));
      end
    end
    check_eq("done_seen_d", 32'(got_d), 32'd1);
    check_eq("done_seen_s", 32'(got_s), 32'd1);
    $display("conv d: %0d -> %h lzb=%b ovf=%b | s: %0d -> %h lzb=%b ovf=%b",
             vd, d_bcd, d_lzb, d_ovf, vs, s_bcd, s_lzb, s_ovf);
  endtask

  int          tv_d[6]  = '{0, 59, 9999, 10000, 16383, 1};
  logic [15:0] te_bd[6] = '{16'h0000, 16'h0059, 16'h9999, 16'h9999, 16'h9999, 16'h0001};
  logic [3:0]  te_ld[6] = '{4'b1110, 4'b1100, 4'b0000, 4'b0000, 4'b0000, 4'b1110};
  logic        te_od[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  int          tv_s[6]  = '{0, 59, 999, 1000, 1023, 100};
  logic [11:0] te_bs[6] = '{12'h000, 12'h059, 12'h999, 12'h999, 12'h999, 12'h100};
  logic [2:0]  te_ls[6] = '{3'b110, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000};
  logic        te_os[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    int lat;
    int extra;
    int vd, vs;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(d_busy), 32'd0);
    check_eq("rst_done", 32'(d_done), 32'd0);
    check_eq("rst_bcd", 32'(d_bcd), 32'd0);
    check_eq("rst_lzb", 32'(d_lzb), 32'b1110);
    check_eq("rst_ovf", 32'(d_ovf), 32'd0);
    check_eq("rst_lzb_s", 32'(s_lzb), 32'b110);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++)
      run_both(tv_d[i], te_bd[i], te_ld[i], te_od[i], tv_s[i], te_bs[i], te_ls[i], te_os[i]);

    // START while busy must be ignored
    d_bin = 14'd1234; d_start = 1'b1;
    @(posedge clk); #1;
    d_start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    d_bin = 14'd5678; d_start = 1'b1;
    @(posedge clk); #1;
    d_start = 1'b0;
    wait_d(3, lat);
    check_eq("ign_lat", lat, 15);
    check_eq("ign_bcd", 32'(d_bcd), 32'h1234);
    extra = 0;
    repeat (20) begin @(posedge clk); #1; if (d_done) extra++; end
    check_eq("ign_no_second_done", extra, 0);
    $display("conv d: 1234 with ignored 5678 -> %h", d_bcd);

    // START in the DONE cycle is accepted
    d_bin = 14'd1234; d_start = 1'b1;
    @(posedge clk); #1;
    d_start = 1'b0;
    wait_d(0, lat);
    check_eq("b2b_lat1", lat, 15);
    check_eq("b2b_bcd1", 32'(d_bcd), 32'h1234);
    d_bin = 14'd42; d_start = 1'b1;
    @(posedge clk); #1;
    d_start = 1'b0;
    check_eq("b2b_done_drop", 32'(d_done), 32'd0);
    check_eq("b2b_busy", 32'(d_busy), 32'd1);
    check_eq("b2b_hold", 32'(d_bcd), 32'h1234);
    wait_d(0, lat);
    check_eq("b2b_lat2", lat, 15);
    check_eq("b2b_bcd2", 32'(d_bcd), 32'h0042);
    check_eq("b2b_lzb2", 32'(d_lzb), 32'b1100);
    $display("conv d: 1234 then 42 -> %h", d_bcd);

    // Reset mid-conversion aborts with no DONE
    d_bin = 14'd777; d_start = 1'b1;
    @(posedge clk); #1;
    d_start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("abort_busy", 32'(d_busy), 32'd0);
    check_eq("abort_done", 32'(d_done), 32'd0);
    check_eq("abort_bcd", 32'(d_bcd), 32'd0);
    check_eq("abort_lzb", 32'(d_lzb), 32'b1110);
    check_eq("abort_ovf", 32'(d_ovf), 32'd0);
    extra = 0;
    repeat (20) begin @(posedge clk); #1; if (d_done) extra++; end
    check_eq("abort_no_done", extra, 0);
    d_bin = 14'd777; d_start = 1'b1;
    @(posedge clk); #1;
    d_start = 1'b0;
    wait_d(0, lat);
    check_eq("abort_lat", lat, 15);
    check_eq("abort_bcd2", 32'(d_bcd), 32'h0777);
    check_eq("abort_lzb2", 32'(d_lzb), 32'b1000);
    $display("conv d: 777 after abort -> %h", d_bcd);

    for (int i = 0; i < 1000; i++) begin
      vd = int'($urandom_range(0, 16383));
      vs = int'($urandom_range(0, 1023));
      run_both(vd, 16'(ref_bcd(vd, 4)), 4'(ref_lzb(vd, 4)), (vd >= 10000),
               vs, 12'(ref_bcd(vs, 3)), 3'(ref_lzb(vs, 3)), (vs >= 1000));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
